// File: rtl/fwd_ctrl.sv
// fwd_ctrl -- operand forwarding and load-use hazard control for the
// 5-stage core (IF/ID/EX/MEM/WB).
//
// The block keeps its own shadow copy of the destination and source tags
// of the instructions in EX, MEM and WB. From that copy it drives the EX
// operand multiplexer selects and the load-use stall.
//
// Ports:
//   clk, rst_n            core clock; asynchronous active-low reset
//   id_valid              ID holds a real instruction
//   id_rs1, id_rs2        ID source register indices
//   id_use_rs1/2          the ID instruction actually reads that source
//   id_rd                 ID destination register index
//   id_reg_write          the ID instruction writes rd
//   id_mem_read           the ID instruction is a load
//   flush                 redirect; squashes ID and EX (overrides stall)
//   fwd_a_sel, fwd_b_sel  EX operand selects: 00 regfile, 01 EX/MEM, 1x WB
//   stall                 hold PC and IF/ID, insert a bubble into EX
//   stall_cnt             saturating count of stall cycles
module fwd_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      flush,
  output logic [1:0]                fwd_a_sel,
  output logic [1:0]                fwd_b_sel,
  output logic                      stall,
  output logic [CNT_WIDTH-1:0]      stall_cnt
);

  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0]      CNT_MAX  = '1;

  // EX shadow stage
  logic                      ex_valid_reg;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_reg;
  logic                      ex_wr_reg;
  logic                      ex_ld_reg;
  logic [REG_ADDR_WIDTH-1:0] ex_rs1_reg;
  logic [REG_ADDR_WIDTH-1:0] ex_rs2_reg;
  logic                      ex_use1_reg;
  logic                      ex_use2_reg;
  // MEM shadow stage
  logic                      mem_valid_reg;
  logic [REG_ADDR_WIDTH-1:0] mem_rd_reg;
  logic                      mem_wr_reg;
  logic                      mem_ld_reg;
  // WB shadow stage
  logic                      wb_valid_reg;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_reg;
  logic                      wb_wr_reg;

  logic [CNT_WIDTH-1:0]      stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_reg  <= 1'b0;
      ex_rd_reg     <= '0;
      ex_wr_reg     <= 1'b0;
      ex_ld_reg     <= 1'b0;
      ex_rs1_reg    <= '0;
      ex_rs2_reg    <= '0;
      ex_use1_reg   <= 1'b0;
      ex_use2_reg   <= 1'b0;
      mem_valid_reg <= 1'b0;
      mem_rd_reg    <= '0;
      mem_wr_reg    <= 1'b0;
      mem_ld_reg    <= 1'b0;
      wb_valid_reg  <= 1'b0;
      wb_rd_reg     <= '0;
      wb_wr_reg     <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      // A stalled or flushed ID instruction enters EX as a bubble: only
      // the valid bit is dropped, the tags are still captured.
      ex_valid_reg  <= id_valid & ~stall & ~flush;
      ex_rd_reg     <= id_rd;
      ex_wr_reg     <= id_reg_write;
      ex_ld_reg     <= id_mem_read;
      ex_rs1_reg    <= id_rs1;
      ex_rs2_reg    <= id_rs2;
      ex_use1_reg   <= id_use_rs1;
      ex_use2_reg   <= id_use_rs2;
      mem_valid_reg <= ex_valid_reg;
      mem_rd_reg    <= ex_rd_reg;
      mem_wr_reg    <= ex_wr_reg;
      mem_ld_reg    <= ex_ld_reg;
      wb_valid_reg  <= mem_valid_reg;
      wb_rd_reg     <= mem_rd_reg;
      wb_wr_reg     <= mem_wr_reg;
      if (stall && (stall_cnt_reg != CNT_MAX)) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;

  // Load-use: the load in EX has no data until it leaves MEM, so the
  // consumer waits one cycle. Flush already bubbles EX, so it masks stall.
  logic load_in_ex;
  assign load_in_ex = ex_valid_reg & ex_ld_reg & (ex_rd_reg != REG_ZERO);
  assign stall = id_valid & load_in_ex
               & ((id_use_rs1 & (id_rs1 == ex_rd_reg)) |
                  (id_use_rs2 & (id_rs2 == ex_rd_reg)))
               & ~flush;

  // Producers able to forward. A load in MEM has no result on the EX/MEM
  // path yet, so it is excluded there and the WB check decides instead.
  logic mem_can_fwd;
  logic wb_can_fwd;
  assign mem_can_fwd = mem_valid_reg & mem_wr_reg & ~mem_ld_reg & (mem_rd_reg != REG_ZERO);
  assign wb_can_fwd  = wb_valid_reg & wb_wr_reg & (wb_rd_reg != REG_ZERO);

  logic [REG_ADDR_WIDTH-1:0] src_rs [2];
  logic [1:0]                src_use;
  assign src_rs[0]  = ex_rs1_reg;
  assign src_rs[1]  = ex_rs2_reg;
  assign src_use[0] = ex_use1_reg;
  assign src_use[1] = ex_use2_reg;

  // One select per EX operand; MEM (the younger producer) beats WB.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opsel
      logic [1:0] sel;
      always_comb begin
        sel = 2'b00;
        if (src_use[gi] && mem_can_fwd && (mem_rd_reg == src_rs[gi])) begin
          sel = 2'b01;
        end else if (src_use[gi] && wb_can_fwd && (wb_rd_reg == src_rs[gi])) begin
          sel = 2'b10;
        end
      end
    end
  endgenerate

  assign fwd_a_sel = g_opsel[0].sel;
  assign fwd_b_sel = g_opsel[1].sel;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Testbench for fwd_ctrl: directed vector table, asynchronous reset
// checks, randomized run against a pipeline-history model, and counter
// saturation with a 4-bit counter instance.
module tb_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, flush;

  logic [1:0]  a16, b16, a4, b4;
  logic        s16, s4;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  fwd_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .fwd_a_sel(a16), .fwd_b_sel(b16), .stall(s16), .stall_cnt(cnt16)
  );

  fwd_ctrl #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .fwd_a_sel(a4), .fwd_b_sel(b4), .stall(s4), .stall_cnt(cnt4)
  );

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } instr_t;

  typedef struct packed {
    instr_t     id;
    logic       fl;
    logic [1:0] ea;
    logic [1:0] eb;
    logic       es;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Model: the last three instructions issued into EX, youngest first
  // (0 = EX, 1 = MEM, 2 = WB), plus the two expected counter values.
  instr_t hist [3];
  int     m_cnt16;
  int     m_cnt4;
  vec_t   tab [$];

  function automatic instr_t mk(input logic v, input int rs1, input int rs2,
                                input logic u1, input logic u2, input int rd,
                                input logic wr, input logic ld);
    instr_t t;
    t.valid = v;
    t.rs1 = 5'(rs1);
    t.rs2 = 5'(rs2);
    t.u1 = u1;
    t.u2 = u2;
    t.rd = 5'(rd);
    t.wr = wr;
    t.ld = ld;
    return t;
  endfunction

  function automatic instr_t nop();
    return mk(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endfunction

  function automatic instr_t alu(input int rd, input int rs1, input int rs2);
    return mk(1'b1, rs1, rs2, 1'b1, 1'b1, rd, 1'b1, 1'b0);
  endfunction

  function automatic instr_t lw(input int rd, input int rs1);
    return mk(1'b1, rs1, 0, 1'b1, 1'b0, rd, 1'b1, 1'b1);
  endfunction

  // Does an older instruction deliver register r?
  function automatic bit produces(input instr_t p, input logic [4:0] r);
    return p.valid && p.wr && (p.rd == r) && (r != 5'd0);
  endfunction

  // Youngest usable producer wins; a load one ahead has no data to offer.
  function automatic logic [1:0] ref_sel(input logic [4:0] r, input logic used);
    if (!used) return 2'b00;
    if (produces(hist[1], r) && !hist[1].ld) return 2'b01;
    if (produces(hist[2], r)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic ref_stall(input instr_t id, input logic fl);
    instr_t p;
    p = hist[0];
    if (fl || !id.valid || !p.valid || !p.ld || p.rd == 5'd0) return 1'b0;
    return (id.u1 && id.rs1 == p.rd) || (id.u2 && id.rs2 == p.rd);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) hist[i] = nop();
    m_cnt16 = 0;
    m_cnt4  = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(input instr_t id, input logic fl);
    id_valid     = id.valid;
    id_rs1       = id.rs1;
    id_rs2       = id.rs2;
    id_use_rs1   = id.u1;
    id_use_rs2   = id.u2;
    id_rd        = id.rd;
    id_reg_write = id.wr;
    id_mem_read  = id.ld;
    flush        = fl;
  endtask

  task automatic add_row(input instr_t id, input logic fl, input logic [1:0] ea,
                         input logic [1:0] eb, input logic es);
    vec_t v;
    v.id = id;
    v.fl = fl;
    v.ea = ea;
    v.eb = eb;
    v.es = es;
    tab.push_back(v);
  endtask

  // One clock cycle: called just after a rising edge. If use_tab is set the
  // selects/stall are compared with the supplied constants, otherwise with
  // the model. Counters always come from the model.
  task automatic run_cycle(input string tag, input instr_t id, input logic fl,
                           input logic use_tab, input logic [1:0] ta,
                           input logic [1:0] tb2, input logic ts);
    logic [1:0] ea, eb;
    logic       es, ms;
    drive(id, fl);
    @(negedge clk);
    ms = ref_stall(id, fl);
    if (use_tab) begin
      ea = ta;
      eb = tb2;
      es = ts;
    end else begin
      ea = ref_sel(hist[0].rs1, hist[0].u1);
      eb = ref_sel(hist[0].rs2, hist[0].u2);
      es = ms;
    end
    chk({tag, ".fwd_a"}, 32'(a16), 32'(ea));
    chk({tag, ".fwd_b"}, 32'(b16), 32'(eb));
    chk({tag, ".stall"}, 32'(s16), 32'(es));
    chk({tag, ".cnt16"}, 32'(cnt16), 32'(m_cnt16));
    chk({tag, ".fwd_a4"}, 32'(a4), 32'(ea));
    chk({tag, ".fwd_b4"}, 32'(b4), 32'(eb));
    chk({tag, ".stall4"}, 32'(s4), 32'(es));
    chk({tag, ".cnt4"}, 32'(cnt4), 32'(m_cnt4));
    $display("%s id(v=%0d rs1=%0d/%0d rs2=%0d/%0d rd=%0d wr=%0d ld=%0d) flush=%0d -> a=%b b=%b stall=%0d cnt=%0d cnt4=%0d",
             tag, id.valid, id.rs1, id.u1, id.rs2, id.u2, id.rd, id.wr, id.ld, fl,
             a16, b16, s16, cnt16, cnt4);
    @(posedge clk);
    #1;
    if (ms) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = id;
    hist[0].valid = id.valid & ~ms & ~fl;
  endtask

  function automatic instr_t rnd_instr();
    instr_t t;
    t.valid = ($urandom_range(3) != 0);
    t.rs1   = 5'($urandom_range(3));
    t.rs2   = 5'($urandom_range(3));
    t.u1    = 1'($urandom_range(1));
    t.u2    = 1'($urandom_range(1));
    t.rd    = 5'($urandom_range(3));
    t.wr    = ($urandom_range(3) != 0);
    t.ld    = ($urandom_range(2) == 0);
    return t;
  endfunction

  task automatic check_cleared(input string tag);
    chk({tag, ".fwd_a"}, 32'(a16), 32'd0);
    chk({tag, ".fwd_b"}, 32'(b16), 32'd0);
    chk({tag, ".stall"}, 32'(s16), 32'd0);
    chk({tag, ".cnt16"}, 32'(cnt16), 32'd0);
    chk({tag, ".cnt4"}, 32'(cnt4), 32'd0);
    $display("%s a=%b b=%b stall=%0d cnt=%0d cnt4=%0d", tag, a16, b16, s16, cnt16, cnt4);
  endtask

  // Hold reset over a few clocks with random inputs, then release between
  // edges and let one clean edge pass with a bubble in ID.
  task automatic reset_hold(input string tag);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(rnd_instr(), 1'($urandom_range(1)));
      @(negedge clk);
      check_cleared(tag);
    end
    rst_n = 1'b1;
    #1;
    check_cleared({tag, ".release"});
    drive(nop(), 1'b0);
    model_reset();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(nop(), 1'b0);
    model_reset();

    // Directed table. Each row is what ID holds that cycle and the selects
    // and stall expected while it sits there.
    // add x5,x1,x2 ; sub x6,x5,x5 -> both 01 when sub is in EX
    add_row(alu(5, 1, 2), 1'b0, 2'b00, 2'b00, 1'b0);
    add_row(alu(6, 5, 5), 1'b0, 2'b00, 2'b00, 1'b0);
    add_row(nop(),        1'b0, 2'b01, 2'b01, 1'b0);
    add_row(nop(),        1'b0, 2'b00, 2'b00, 1'b0);
    add_row(nop(),        1'b0, 2'b00, 2'b00, 1'b0);
    // add x5 ; addi x10,x11 ; sub x6,x5,x5 -> both 10
    add_row(alu(5, 1, 2), 1'b0, 2'b00, 2'b00, 1'b0);
    add_row(mk(1'b1, 11, 0, 1'b1, 1'b0, 10, 1'b1, 1'b0), 1'b0, 2'b00, 2'b00, 1'b0);
    add_row(alu(6, 5, 5), 1'b0, 2'b00, 2'b00, 1'b0);
    add_row(nop(),        1'b0, 2'b10, 2'b10, 1'b0);
    add_row(nop(),        1'b0, 2'b00, 2'b00, 1'b0);
    add_row(nop(),        1'b0, 2'b00, 2'b00, 1'b0);
    // lw x7,0(x1) ; add x8,x7,x3 -> one stall, bubble, then a=10 b=00
    add_row(lw(7, 1),     1'b0, 2'b00, 2'b00, 1'b0);
    add_row(alu(8, 7, 3), 1'b0, 2'b00, 2'b00, 1'b1);
    add_row(alu(8, 7, 3), 1'b0, 2'b00, 2'b00, 1'b0);
    add_row(nop(),        1'b0, 2'b10, 2'b00, 1'b0);
    add_row(nop(),        1'b0, 2'b00, 2'b00, 1'b0);
    add_row(nop(),        1'b0, 2'b00, 2'b00, 1'b0);
    // producer of x0 then consumer of x0; lw x4 then rs2=4 unused
    add_row(alu(0, 1, 2), 1'b0, 2'b00, 2'b00, 1'b0);
    add_row(mk(1'b1, 0, 0, 1'b1, 1'b1, 3, 1'b1, 1'b0), 1'b0, 2'b00, 2'b00, 1'b0);
    add_row(nop(),        1'b0, 2'b00, 2'b00, 1'b0);
    add_row(lw(4, 1),     1'b0, 2'b00, 2'b00, 1'b0);
    add_row(mk(1'b1, 5, 4, 1'b1, 1'b0, 6, 1'b1, 1'b0), 1'b0, 2'b00, 2'b00, 1'b0);
    add_row(nop(),        1'b0, 2'b00, 2'b00, 1'b0);
    add_row(nop(),        1'b0, 2'b00, 2'b00, 1'b0);
    add_row(nop(),        1'b0, 2'b00, 2'b00, 1'b0);
    // two writes of x9, then sub x10,x9,x1 -> a=01 (MEM beats WB)
    add_row(alu(9, 1, 2),  1'b0, 2'b00, 2'b00, 1'b0);
    add_row(alu(9, 3, 4),  1'b0, 2'b00, 2'b00, 1'b0);
    add_row(alu(10, 9, 1), 1'b0, 2'b00, 2'b00, 1'b0);
    add_row(nop(),         1'b0, 2'b01, 2'b00, 1'b0);
    add_row(nop(),         1'b0, 2'b00, 2'b00, 1'b0);
    add_row(nop(),         1'b0, 2'b00, 2'b00, 1'b0);
    // load-use with flush in the hazard cycle: no stall, EX bubble
    add_row(lw(7, 1),     1'b0, 2'b00, 2'b00, 1'b0);
    add_row(alu(8, 7, 3), 1'b1, 2'b00, 2'b00, 1'b0);
    add_row(nop(),        1'b0, 2'b00, 2'b00, 1'b0);
    add_row(nop(),        1'b0, 2'b00, 2'b00, 1'b0);
    add_row(nop(),        1'b0, 2'b00, 2'b00, 1'b0);

    reset_hold("reset");

    foreach (tab[i]) begin
      run_cycle($sformatf("vec%0d", i), tab[i].id, tab[i].fl, 1'b1,
                tab[i].ea, tab[i].eb, tab[i].es);
    end
    chk("vec.cnt_after_table", 32'(cnt16), 32'd1);

    // Asynchronous clear: reach a stall cycle, then drop rst_n between edges.
    run_cycle("pre_rst", lw(7, 1), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    drive(alu(8, 7, 3), 1'b0);
    @(negedge clk);
    chk("pre_rst.stall", 32'(s16), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("async_rst");
    @(posedge clk);
    #1;
    reset_hold("async_hold");

    // Randomized run against the model.
    for (int i = 0; i < 300; i++) begin
      run_cycle($sformatf("rnd%0d", i), rnd_instr(), ($urandom_range(7) == 0),
                1'b0, 2'b00, 2'b00, 1'b0);
    end

    // Saturation: 20 load-use hazards after a fresh reset.
    reset_hold("sat_rst");
    for (int k = 0; k < 20; k++) begin
      run_cycle($sformatf("sat%0d.lw", k), lw(7, 1), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
      run_cycle($sformatf("sat%0d.use", k), alu(8, 7, 3), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
      run_cycle($sformatf("sat%0d.held", k), alu(8, 7, 3), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    end
    run_cycle("sat.end", nop(), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    chk("sat.cnt4_final", 32'(cnt4), 32'd15);
    chk("sat.cnt16_final", 32'(cnt16), 32'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
